// File: rtl/fsk_tx_scheduler.sv
// fsk_tx_scheduler: two-requester round-robin FSK frame scheduler.
// Frame = alternating preamble, LSB-first payload byte, idle gap.
module fsk_tx_scheduler #(
  parameter int SYM_CYCLES = 256,
  parameter int PRE_BITS   = 8,
  parameter int GAP_SYMS   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic [1:0] grant,
  output logic       busy,
  output logic       sym_bit,
  output logic       sym_valid,
  output logic       sym_stb,
  output logic       src_id,
  output logic       frame_done
);

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    DATA,
    GAP
  } state_t;

  localparam logic [15:0] SYM_LAST = 16'(SYM_CYCLES - 1);
  localparam logic [15:0] SYM_PEN  = 16'(SYM_CYCLES - 2);
  localparam logic [7:0]  PRE_LAST = 8'(PRE_BITS - 1);
  localparam logic [7:0]  GAP_LAST = 8'(GAP_SYMS - 1);

  state_t      state;
  logic [15:0] symCnt;
  logic [7:0]  bitCnt;
  logic [7:0]  payload;
  logic        rrPtr;
  logic        winner;
  logic        symWrap;
  logic        doneNext;
  logic [2:0]  nextIdx;

  // rrPtr names the requester that wins a tie
  always_comb begin
    winner = 1'b0;
    unique case (1'b1)
      (req == 2'b10): winner = 1'b1;
      (req == 2'b11): winner = rrPtr;
      default:        winner = 1'b0;
    endcase
  end

  assign symWrap  = (symCnt == SYM_LAST);
  assign doneNext = (state == GAP) &&
                    (bitCnt == GAP_LAST) &&
                    (symCnt == SYM_PEN);
  assign nextIdx  = bitCnt[2:0] + 3'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      symCnt     <= '0;
      bitCnt     <= '0;
      payload    <= '0;
      rrPtr      <= 1'b0;
      grant      <= '0;
      busy       <= 1'b0;
      sym_bit    <= 1'b0;
      sym_valid  <= 1'b0;
      sym_stb    <= 1'b0;
      src_id     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      grant      <= '0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          sym_stb   <= 1'b0;
          sym_valid <= 1'b0;
          sym_bit   <= 1'b0;
          if (|req) begin
            grant     <= winner ? 2'b10 : 2'b01;
            src_id    <= winner;
            rrPtr     <= ~winner;
            payload   <= winner ? data1 : data0;
            state     <= PREAMBLE;
            symCnt    <= '0;
            bitCnt    <= '0;
            busy      <= 1'b1;
            sym_stb   <= 1'b1;
            sym_valid <= 1'b1;
            sym_bit   <= 1'b1;
          end
        end
        default: begin
          if (!symWrap) begin
            symCnt  <= symCnt + 16'd1;
            sym_stb <= 1'b0;
            if (doneNext) frame_done <= 1'b1;
          end else begin
            symCnt  <= '0;
            sym_stb <= 1'b1;
            case (state)
              PREAMBLE: begin
                if (bitCnt == PRE_LAST) begin
                  state   <= DATA;
                  bitCnt  <= '0;
                  sym_bit <= payload[0];
                end else begin
                  bitCnt  <= bitCnt + 8'd1;
                  sym_bit <= bitCnt[0];
                end
              end
              DATA: begin
                if (bitCnt == 8'd7) begin
                  state     <= GAP;
                  bitCnt    <= '0;
                  sym_bit   <= 1'b0;
                  sym_valid <= 1'b0;
                end else begin
                  bitCnt  <= bitCnt + 8'd1;
                  sym_bit <= payload[nextIdx];
                end
              end
              default: begin
                if (bitCnt == GAP_LAST) begin
                  state   <= IDLE;
                  bitCnt  <= '0;
                  busy    <= 1'b0;
                  sym_stb <= 1'b0;
                end else begin
                  bitCnt <= bitCnt + 8'd1;
                end
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsk_tx_scheduler.sv
// Scoreboard bench for fsk_tx_scheduler: small-parameter instance
// plus a default-parameter instance for full frame length.
module tb_fsk_tx_scheduler;

  localparam int SYM  = 4;
  localparam int FLEN = 44;
  localparam int NSTB = 11;
  localparam int NVAL = 40;
  localparam int DSYM  = 256;
  localparam int DFLEN = 4608;
  localparam int DNVAL = 4096;
  localparam int DNSTB = 18;

  typedef struct {
    logic       src;
    logic [9:0] seq;
    int         gcyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, rstD;
  logic [1:0] req, reqD;
  logic [7:0] data0, data1, data0D, data1D;
  logic [1:0] grant, grantD;
  logic       busy, symBit, symValid, symStb, srcId, frameDone;
  logic       busyD, symBitD, symValidD, symStbD, srcIdD, frameDoneD;

  int nPass = 0;
  int nTot  = 0;
  int cyc   = 0;

  exp_t q[$];
  exp_t qd[$];

  fsk_tx_scheduler #(
    .SYM_CYCLES(4), .PRE_BITS(2), .GAP_SYMS(1)
  ) dut (
    .clk(clk), .rst(rst), .req(req),
    .data0(data0), .data1(data1),
    .grant(grant), .busy(busy),
    .sym_bit(symBit), .sym_valid(symValid),
    .sym_stb(symStb), .src_id(srcId),
    .frame_done(frameDone)
  );

  fsk_tx_scheduler dutDef (
    .clk(clk), .rst(rstD), .req(reqD),
    .data0(data0D), .data1(data1D),
    .grant(grantD), .busy(busyD),
    .sym_bit(symBitD), .sym_valid(symValidD),
    .sym_stb(symStbD), .src_id(srcIdD),
    .frame_done(frameDoneD)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, int act, int exp);
    nTot++;
    if (act == exp) nPass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(logic s, logic [9:0] sq, int g);
    exp_t e;
    e.src = s;
    e.seq = sq;
    e.gcyc = g;
    q.push_back(e);
  endtask

  // monitor for the small instance
  exp_t cur;
  bit   active = 0;
  bit   busyChk = 0;
  int   pos, idx, stbN, valN, errN;

  always @(negedge clk) begin
    if (rst) begin
      active  = 0;
      busyChk = 0;
    end else begin
      if (busyChk) begin
        chk("idle_after_done", {busy, grant}, 0);
        busyChk = 0;
      end
      if (grant != 2'b00) begin
        if (q.size() == 0) begin
          chk("unexpected_grant", grant, 0);
        end else begin
          cur = q.pop_front();
          chk("grant_onehot", grant, cur.src ? 2 : 1);
          chk("src_id", srcId, cur.src);
          chk("grant_cycle", cyc, cur.gcyc);
          chk("busy_at_grant", busy, 1);
        end
        active = 1;
        pos = 0;
        stbN = 0;
        valN = 0;
        errN = 0;
      end
      if (active) begin
        idx = pos / SYM;
        if (symStb) stbN++;
        if (symValid) valN++;
        if (symStb != ((pos % SYM) == 0)) errN++;
        if (!busy) errN++;
        if (idx < 10) begin
          if (!symValid || symBit != cur.seq[9 - idx]) errN++;
        end else if (symValid || symBit) begin
          errN++;
        end
        if (frameDone) begin
          chk("frame_len", pos + 1, FLEN);
          chk("stb_count", stbN, NSTB);
          chk("valid_cycles", valN, NVAL);
          chk("symbol_errors", errN, 0);
          active = 0;
          busyChk = 1;
        end else if (pos == FLEN - 1) begin
          chk("frame_done_missing", frameDone, 1);
          active = 0;
        end
        pos++;
      end else if (frameDone) begin
        chk("stray_frame_done", frameDone, 0);
      end
    end
  end

  // monitor for the default-parameter instance
  logic [15:0] seqD = 16'b1010101000000000;
  exp_t curD;
  bit   actD = 0;
  int   posD, stbD, valD, errD;

  always @(negedge clk) begin
    if (!rstD) begin
      if (grantD != 2'b00) begin
        if (qd.size() == 0) begin
          chk("def_unexpected_grant", grantD, 0);
        end else begin
          curD = qd.pop_front();
          chk("def_grant", grantD, 2);
          chk("def_src_id", srcIdD, curD.src);
          chk("def_grant_cycle", cyc, curD.gcyc);
        end
        actD = 1;
        posD = 0;
        stbD = 0;
        valD = 0;
        errD = 0;
      end
      if (actD) begin
        if (symStbD) stbD++;
        if (symValidD) valD++;
        if (posD / DSYM < 16) begin
          if (symBitD != seqD[15 - posD / DSYM]) errD++;
        end else if (symBitD) begin
          errD++;
        end
        if (frameDoneD) begin
          chk("def_frame_len", posD + 1, DFLEN);
          chk("def_valid_cycles", valD, DNVAL);
          chk("def_stb_count", stbD, DNSTB);
          chk("def_symbol_errors", errD, 0);
          actD = 0;
        end else if (posD == DFLEN - 1) begin
          chk("def_frame_done_missing", frameDoneD, 1);
          actD = 0;
        end
        posD++;
      end
    end
  end

  initial begin
    rst = 1'b1;
    req = 2'b00;
    data0 = 8'h00;
    data1 = 8'h00;
    rstD = 1'b1;
    reqD = 2'b00;
    data0D = 8'h00;
    data1D = 8'h00;
    tick(3);
    @(negedge clk);
    chk("reset_outputs",
        {grant, busy, symBit, symValid, symStb, srcId, frameDone}, 0);
    tick(1);

    // single request, 0xA5
    rst = 1'b0;
    req = 2'b01;
    data0 = 8'hA5;
    push(1'b0, 10'b10_10100101, cyc + 1);
    tick(1);
    req = 2'b00;
    tick(50);

    // payload changes mid-frame
    req = 2'b01;
    data0 = 8'hFF;
    push(1'b0, 10'b10_11111111, cyc + 1);
    tick(1);
    req = 2'b00;
    tick(10);
    data0 = 8'h00;
    tick(45);

    // req[1] pulses during a requester-0 frame
    req = 2'b01;
    data0 = 8'h35;
    push(1'b0, 10'b10_10101100, cyc + 1);
    tick(1);
    req = 2'b00;
    tick(5);
    req = 2'b10;
    data1 = 8'h77;
    tick(10);
    req = 2'b00;
    tick(45);

    // both requesting from reset release
    rst = 1'b1;
    tick(2);
    @(negedge clk);
    chk("reset_outputs_2",
        {grant, busy, symBit, symValid, symStb, srcId, frameDone}, 0);
    tick(1);
    req = 2'b11;
    data0 = 8'h11;
    data1 = 8'h22;
    rst = 1'b0;
    push(1'b0, 10'b10_10001000, cyc + 1);
    push(1'b1, 10'b10_01000100, cyc + 46);
    push(1'b0, 10'b10_10001000, cyc + 91);
    tick(92);
    req = 2'b00;
    tick(50);

    // reset in the third data symbol, req held
    req = 2'b01;
    data0 = 8'h1E;
    push(1'b0, 10'b10_01111000, cyc + 1);
    tick(18);
    rst = 1'b1;
    tick(1);
    @(negedge clk);
    chk("reset_abort_outputs",
        {grant, busy, symBit, symValid, symStb, srcId, frameDone}, 0);
    tick(1);
    rst = 1'b0;
    push(1'b0, 10'b10_01111000, cyc + 1);
    tick(1);
    req = 2'b00;
    tick(50);

    // default parameters, requester 1, payload 0x00
    rstD = 1'b0;
    reqD = 2'b10;
    data1D = 8'h00;
    curD.src = 1'b1;
    curD.seq = '0;
    curD.gcyc = cyc + 1;
    qd.push_back(curD);
    tick(1);
    reqD = 2'b00;
    tick(4620);

    chk("scoreboard_drained", q.size(), 0);
    chk("def_scoreboard_drained", qd.size(), 0);
    chk("no_open_frame", {active, actD}, 0);
    $display("%0d/%0d checks passed", nPass, nTot);
    $finish;
  end

endmodule
